// File: rtl/reg_read_scoreboard.sv
// ---------------------------------------------------------------------------
// reg_read_scoreboard
//   Register-read stage with a per-register pending scoreboard. It holds the
//   32-entry register file and accepts writebacks. It reads rs/rt operands
//   for execute and stalls issue on RAW/WAW hazards against in-flight
//   destination writes.
//
//   Configuration macro: REG_READ_BYPASS_EN
//     defined   : a same-cycle writeback releases a dependent issue, and
//                 wb_data is forwarded into rs_data/rt_data.
//     undefined : the dependent issue waits one extra cycle and reads the
//                 array. No forwarding mux is built.
//
//   Ports
//     clk, reset              : rising-edge clock, synchronous active-high reset
//     in_valid / in_ready     : decode handshake (in_ready is combinational)
//     rs, rt, dest, dest_we   : decoded sources, destination and its write flag
//     wb_en, wb_reg, wb_data  : writeback port (writes to r0 are dropped)
//     out_valid / out_ready   : execute handshake
//     rs_data, rt_data        : registered operand values
//     out_dest, out_dest_we   : registered destination and its write flag
//     stall_count             : saturating count of cycles with in_valid && !in_ready
// ---------------------------------------------------------------------------
module reg_read_scoreboard #(
  parameter int DATA_W      = 32,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4:0]             rs,
  input  logic [4:0]             rt,
  input  logic [4:0]             dest,
  input  logic                   dest_we,
  input  logic                   wb_en,
  input  logic [4:0]             wb_reg,
  input  logic [DATA_W-1:0]      wb_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      rs_data,
  output logic [DATA_W-1:0]      rt_data,
  output logic [4:0]             out_dest,
  output logic                   out_dest_we,
  output logic [STALL_CNT_W-1:0] stall_count
);

  localparam logic [STALL_CNT_W-1:0] STALL_MAX = {STALL_CNT_W{1'b1}};
  localparam logic [STALL_CNT_W-1:0] STALL_ONE = {{(STALL_CNT_W-1){1'b0}}, 1'b1};

  logic [DATA_W-1:0]      r_regs [32];
  logic [31:0]            r_pending;
  logic                   r_out_valid;
  logic [DATA_W-1:0]      r_rs_data;
  logic [DATA_W-1:0]      r_rt_data;
  logic [4:0]             r_out_dest;
  logic                   r_out_dest_we;
  logic [STALL_CNT_W-1:0] r_stall_count;

  logic [31:0]            w_clr;
  logic [31:0]            w_set;
  logic [31:0]            w_eff_pend;
  logic [31:0]            w_pending_next;
  logic                   w_hazard;
  logic                   w_ready;
  logic                   w_accept;
  logic [DATA_W-1:0]      w_rs_val;
  logic [DATA_W-1:0]      w_rt_val;

  // One-hot writeback clear vector. r0 is never tracked.
  always_comb begin
    w_clr = 32'd0;
    if (wb_en && (wb_reg != 5'd0)) begin
      w_clr[wb_reg] = 1'b1;
    end else begin
      w_clr = 32'd0;
    end
  end

`ifdef REG_READ_BYPASS_EN
  // A register being written back this cycle no longer blocks issue.
  assign w_eff_pend = r_pending & ~w_clr;
  // Write-first forwarding of the in-flight writeback value.
  assign w_rs_val   = w_clr[rs] ? wb_data : r_regs[rs];
  assign w_rt_val   = w_clr[rt] ? wb_data : r_regs[rt];
`else
  assign w_eff_pend = r_pending;
  assign w_rs_val   = r_regs[rs];
  assign w_rt_val   = r_regs[rt];
`endif

  assign w_hazard = w_eff_pend[rs] | w_eff_pend[rt] | (dest_we & w_eff_pend[dest]);
  assign w_ready  = (!r_out_valid || out_ready) && !w_hazard;
  assign w_accept = in_valid && w_ready;

  // Scoreboard update: when a register is set and cleared in the same
  // cycle, the set wins, so a re-issued writer keeps its register pending.
  always_comb begin
    w_set = 32'd0;
    if (w_accept && dest_we && (dest != 5'd0)) begin
      w_set[dest] = 1'b1;
    end else begin
      w_set = 32'd0;
    end
    w_pending_next = (r_pending & ~w_clr) | w_set;
  end

  // Register file storage. r0 is never written, so it always reads zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        r_regs[i] <= '0;
      end
    end else if (wb_en && (wb_reg != 5'd0)) begin
      r_regs[wb_reg] <= wb_data;
    end
  end

  // Pending-bit register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pending <= 32'd0;
    end else begin
      r_pending <= w_pending_next;
    end
  end

  // Output bundle. On accept it loads the bundle. Without an accept it holds
  // while execute is stalled, and drops out_valid when execute takes it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid   <= 1'b0;
      r_rs_data     <= '0;
      r_rt_data     <= '0;
      r_out_dest    <= 5'd0;
      r_out_dest_we <= 1'b0;
    end else if (w_accept) begin
      r_out_valid   <= 1'b1;
      r_rs_data     <= w_rs_val;
      r_rt_data     <= w_rt_val;
      r_out_dest    <= dest;
      r_out_dest_we <= dest_we;
    end else if (out_ready) begin
      r_out_valid   <= 1'b0;
    end
  end

  // Saturating stall counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_count <= '0;
    end else if (in_valid && !w_ready && (r_stall_count != STALL_MAX)) begin
      r_stall_count <= r_stall_count + STALL_ONE;
    end
  end

  assign in_ready    = w_ready;
  assign out_valid   = r_out_valid;
  assign rs_data     = r_rs_data;
  assign rt_data     = r_rt_data;
  assign out_dest    = r_out_dest;
  assign out_dest_we = r_out_dest_we;
  assign stall_count = r_stall_count;

endmodule

// File: tb/tb_reg_read_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_reg_read_scoreboard
//   Directed testbench for reg_read_scoreboard. Inputs change 1 time unit
//   after a rising edge. in_ready is sampled 1 time unit after the inputs
//   change. Registered outputs are sampled 1 time unit after the edge.
//   Expectations follow REG_READ_BYPASS_EN when that macro is defined.
// ---------------------------------------------------------------------------
module tb_reg_read_scoreboard;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  rs, rt, dest;
  logic        dest_we;
  logic        wb_en;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] rs_data, rt_data;
  logic [4:0]  out_dest;
  logic        out_dest_we;
  logic [15:0] stall_count;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_stall = 16'd0;

  always #5 clk = ~clk;

  reg_read_scoreboard #(.DATA_W(32), .STALL_CNT_W(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .rs(rs), .rt(rt), .dest(dest), .dest_we(dest_we),
    .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .rs_data(rs_data), .rt_data(rt_data),
    .out_dest(out_dest), .out_dest_we(out_dest_we),
    .stall_count(stall_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_issue(input logic [4:0] a, input logic [4:0] b,
                             input logic [4:0] d, input logic we);
    in_valid = 1'b1; rs = a; rt = b; dest = d; dest_we = we;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; rs = 5'd0; rt = 5'd0; dest = 5'd0;
    dest_we = 1'b0; wb_en = 1'b0; wb_reg = 5'd0; wb_data = 32'd0; out_ready = 1'b1;
    tick(); tick();
    reset = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    checks++;
    if (rs_data !== 32'd0 || rt_data !== 32'd0) begin
      errors++; $display("FAIL reset_data got %h/%h want 0/0", rs_data, rt_data);
    end
    checks++;
    if (out_dest !== 5'd0 || out_dest_we !== 1'b0) begin
      errors++; $display("FAIL reset_dest got %0d/%0b want 0/0", out_dest, out_dest_we);
    end
    checks++;
    if (stall_count !== 16'd0) begin errors++; $display("FAIL reset_stall got %0d want 0", stall_count); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
  endtask

  task automatic test_basic_read();
    wb_en = 1'b1; wb_reg = 5'd5; wb_data = 32'h0000_00AA;
    tick();
    wb_en = 1'b0;
    drive_issue(5'd5, 5'd0, 5'd0, 1'b0);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_in_ready got %0b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || rs_data !== 32'hAA || rt_data !== 32'd0) begin
      errors++; $display("FAIL basic_read got v=%0b rs=%h rt=%h want v=1 rs=aa rt=0", out_valid, rs_data, rt_data);
    end
    checks++;
    if (stall_count !== 16'd0) begin errors++; $display("FAIL basic_stall got %0d want 0", stall_count); end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_drain got %0b want 0", out_valid); end
  endtask

  task automatic test_raw();
    drive_issue(5'd0, 5'd0, 5'd8, 1'b1);
    tick();
    drive_issue(5'd8, 5'd0, 5'd0, 1'b0);
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL raw_in_ready got %0b want 0", in_ready); end
    tick(); tick();
    exp_stall = exp_stall + 16'd2;
    checks++;
    if (stall_count !== exp_stall) begin errors++; $display("FAIL raw_stall got %0d want %0d", stall_count, exp_stall); end
    wb_en = 1'b1; wb_reg = 5'd8; wb_data = 32'h0000_1234;
    #1;
`ifdef REG_READ_BYPASS_EN
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL raw_bypass_ready got %0b want 1", in_ready); end
    tick();
    wb_en = 1'b0; in_valid = 1'b0;
`else
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL raw_nobypass_ready got %0b want 0", in_ready); end
    tick();
    exp_stall = exp_stall + 16'd1;
    wb_en = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL raw_release_ready got %0b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
`endif
    checks++;
    if (out_valid !== 1'b1 || rs_data !== 32'h0000_1234) begin
      errors++; $display("FAIL raw_data got v=%0b rs=%h want v=1 rs=00001234", out_valid, rs_data);
    end
    checks++;
    if (stall_count !== exp_stall) begin errors++; $display("FAIL raw_stall_final got %0d want %0d", stall_count, exp_stall); end
  endtask

  task automatic test_waw();
    drive_issue(5'd0, 5'd0, 5'd3, 1'b1);
    tick();
    drive_issue(5'd0, 5'd0, 5'd3, 1'b1);
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL waw_in_ready got %0b want 0", in_ready); end
    tick();
    exp_stall = exp_stall + 16'd1;
    wb_en = 1'b1; wb_reg = 5'd3; wb_data = 32'h0000_0033;
`ifdef REG_READ_BYPASS_EN
    tick();
    wb_en = 1'b0; in_valid = 1'b0;
`else
    tick();
    exp_stall = exp_stall + 16'd1;
    wb_en = 1'b0;
    tick();
    in_valid = 1'b0;
`endif
    checks++;
    if (out_valid !== 1'b1 || out_dest !== 5'd3 || out_dest_we !== 1'b1) begin
      errors++; $display("FAIL waw_accept got v=%0b d=%0d we=%0b want 1/3/1", out_valid, out_dest, out_dest_we);
    end
    // r3 must still be pending after the second writer was accepted.
    rs = 5'd3; rt = 5'd0; dest_we = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL waw_still_pending got %0b want 0", in_ready); end
    checks++;
    if (stall_count !== exp_stall) begin errors++; $display("FAIL waw_stall got %0d want %0d", stall_count, exp_stall); end
    wb_en = 1'b1; wb_reg = 5'd3; wb_data = 32'h0000_0055;
    tick();
    wb_en = 1'b0;
  endtask

  task automatic test_hold();
    drive_issue(5'd5, 5'd3, 5'd10, 1'b1);
    tick();
    drive_issue(5'd0, 5'd0, 5'd0, 1'b0);
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL hold_in_ready[%0d] got %0b want 0", i, in_ready); end
      tick();
      exp_stall = exp_stall + 16'd1;
      checks++;
      if (out_valid !== 1'b1 || rs_data !== 32'hAA || rt_data !== 32'h55 ||
          out_dest !== 5'd10 || out_dest_we !== 1'b1) begin
        errors++;
        $display("FAIL hold_stable[%0d] got v=%0b rs=%h rt=%h d=%0d we=%0b want 1/aa/55/10/1",
                 i, out_valid, rs_data, rt_data, out_dest, out_dest_we);
      end
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL hold_release got %0b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_dest !== 5'd0 || out_dest_we !== 1'b0 || rs_data !== 32'd0) begin
      errors++; $display("FAIL hold_next got v=%0b d=%0d we=%0b rs=%h want 1/0/0/0", out_valid, out_dest, out_dest_we, rs_data);
    end
    checks++;
    if (stall_count !== exp_stall) begin errors++; $display("FAIL hold_stall got %0d want %0d", stall_count, exp_stall); end
    rs = 5'd10;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL hold_pending10 got %0b want 0", in_ready); end
    rs = 5'd0;
  endtask

  task automatic test_reg0();
    wb_en = 1'b1; wb_reg = 5'd0; wb_data = 32'hFFFF_FFFF;
    tick();
    wb_en = 1'b0;
    drive_issue(5'd0, 5'd0, 5'd0, 1'b1);
    tick();
    checks++;
    if (rs_data !== 32'd0 || out_dest_we !== 1'b1) begin
      errors++; $display("FAIL reg0_read got rs=%h we=%0b want 0/1", rs_data, out_dest_we);
    end
    drive_issue(5'd0, 5'd0, 5'd0, 1'b0);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reg0_no_stall got %0b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    checks++;
    if (rs_data !== 32'd0 || stall_count !== exp_stall) begin
      errors++; $display("FAIL reg0_after got rs=%h stall=%0d want 0/%0d", rs_data, stall_count, exp_stall);
    end
  endtask

  task automatic test_reset_mid();
    drive_issue(5'd0, 5'd0, 5'd9, 1'b1);
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    reset = 1'b1;
    wb_en = 1'b1; wb_reg = 5'd5; wb_data = 32'hDEAD_BEEF;
    tick();
    reset = 1'b0; wb_en = 1'b0; out_ready = 1'b1;
    checks++;
    if (out_valid !== 1'b0 || stall_count !== 16'd0) begin
      errors++; $display("FAIL midreset_state got v=%0b stall=%0d want 0/0", out_valid, stall_count);
    end
    drive_issue(5'd9, 5'd5, 5'd0, 1'b0);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL midreset_ready got %0b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || rs_data !== 32'd0 || rt_data !== 32'd0) begin
      errors++; $display("FAIL midreset_read got v=%0b rs=%h rt=%h want 1/0/0", out_valid, rs_data, rt_data);
    end
  endtask

  initial begin
    test_reset();
    test_basic_read();
    test_raw();
    test_waw();
    test_hold();
    test_reg0();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
